// File: rtl/xnor_serial_comparator.sv
// Bit-serial XNOR/XOR word comparator: one bit per clock, LSB first, reports equality, match count and lowest mismatch index.
// Optional build macro XNOR_CMP_EARLY_EXIT_EN ends the scan on the first mismatching bit.
module xnor_serial_comparator #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1),
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic [CW-1:0]    match_count,
   output logic [IW-1:0]    mismatch_idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_mode;
   logic [IW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_equal;
   logic [CW-1:0]    r_matchCount;
   logic [IW-1:0]    r_mismatchIdx;

   logic             w_load;
   logic             w_step;
   logic             w_bitMatch;
   logic             w_lastBit;

   // Complement mode turns the per-bit XNOR test into an XOR test.
   assign w_bitMatch = r_mode ? (r_a[0] ^ r_b[0]) : ~(r_a[0] ^ r_b[0]);
   assign w_lastBit  = (r_cnt == IW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            w_step = 1'b1;
            if (w_lastBit) begin
               w_nextState = DONE;
            end
`ifdef XNOR_CMP_EARLY_EXIT_EN
            else if (!w_bitMatch) begin
               w_nextState = DONE;
            end
`endif
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // busy/done are registered from the next state so they line up with r_state without a decode path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a           <= '0;
         r_b           <= '0;
         r_mode        <= 1'b0;
         r_cnt         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_equal       <= 1'b0;
         r_matchCount  <= '0;
         r_mismatchIdx <= '0;
      end else begin
         r_busy <= (w_nextState == SHIFT);
         r_done <= (w_nextState == DONE);
         if (w_load) begin
            r_a           <= a;
            r_b           <= b;
            r_mode        <= mode;
            r_cnt         <= '0;
            r_equal       <= 1'b1;
            r_matchCount  <= '0;
            r_mismatchIdx <= '0;
         end else if (w_step) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_cnt <= r_cnt + IW'(1);
            if (w_bitMatch) begin
               r_matchCount <= r_matchCount + CW'(1);
            end else if (r_equal) begin
               r_equal       <= 1'b0;
               r_mismatchIdx <= r_cnt;
            end
         end
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign equal        = r_equal;
   assign match_count  = r_matchCount;
   assign mismatch_idx = r_mismatchIdx;

endmodule

// File: doc/xnor_serial_comparator.md
Name: xnor_serial_comparator

Overview:
- Parametrised, sequential successor to the two-input XNOR equivalence gate.
- Compares two WIDTH-bit words one bit per clock, LSB first, using a per-bit XNOR (or XOR) decision.
- Reports word equality, the number of matching bits and the index of the lowest mismatching bit.
- Used as a low-area equality/complement checker behind register files and test benches in the lab datapath.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CW, $clog2(WIDTH+1), width of match_count (derived, not overridden).
- IW, $clog2(WIDTH), width of mismatch_idx (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a comparison; sampled only in IDLE.
- mode  input  1  0 = equivalence (bit matches when a[i] XNOR b[i] = 1); 1 = complement (bit matches when a[i] XOR b[i] = 1).
- a  input  WIDTH  first operand; captured on accepted start.
- b  input  WIDTH  second operand; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- equal  output  1  1 when every processed bit matched.
- match_count  output  CW  number of matching bits.
- mismatch_idx  output  IW  index of the lowest mismatching bit; 0 when equal = 1.

Behaviour:
- Reset and control:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - Reset forces state IDLE and sets busy, done, equal, match_count and mismatch_idx to 0. It also clears the internal operand shift registers, bit counter and captured mode.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a rising edge with start = 1: capture a, b and mode; clear the bit counter, match_count and mismatch flag; set equal = 1 provisionally; go to SHIFT.
  - With start = 0: stay in IDLE; result outputs hold their last values.
- SHIFT (busy = 1):
  - Each edge evaluates bit 0 of the operand shift registers, then shifts both registers right by one and increments the counter.
  - When the bit matches, match_count increments.
  - On the first mismatch, equal clears and mismatch_idx takes the current counter value. Later mismatches do not change mismatch_idx.
  - The edge that processes bit WIDTH-1 moves the FSM to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then IDLE.
  - Results stay stable until the next accepted start.
- Latency:
  - The start edge is cycle 0; bit i is processed on edge i+1.
  - done is high in the cycle after edge WIDTH.
  - Back-to-back throughput is one comparison per WIDTH+2 cycles.
- start outside IDLE (SHIFT or DONE) is ignored; there is no queuing.
- Changes on a, b or mode after capture have no effect on the comparison in progress.
- Width rule: match_count never exceeds WIDTH and fits CW bits without wrap.
- Reset asserted mid-SHIFT aborts the comparison: no done pulse, all outputs return to 0.
- Combinational loops are not allowed; all outputs are registered.

Optional Feature:
- Macro: XNOR_CMP_EARLY_EXIT_EN.
- Defined:
  - SHIFT goes to DONE on the edge that detects the first mismatch.
  - At that point match_count equals mismatch_idx, and latency is mismatch_idx+1 edges before done.
  - Fully matching words still take WIDTH edges.
- Undefined: SHIFT always runs all WIDTH bits, and match_count is the total over the whole word.

Test Plan:
1. Reset then idle: hold rst_n = 0 for 3 cycles with start = 1 -> busy = done = equal = 0, match_count = 0, mismatch_idx = 0; with rst_n = 1 and start = 0 -> outputs unchanged.
2. Equivalence, equal words: WIDTH = 8, mode = 0, a = b = 8'hA5, start for 1 cycle -> busy for 8 cycles, done in cycle 9, equal = 1, match_count = 8, mismatch_idx = 0.
3. Equivalence, mismatches: mode = 0, a = 8'h0F, b = 8'h0B -> equal = 0, mismatch_idx = 2, match_count = 7. With XNOR_CMP_EARLY_EXIT_EN defined -> done after 3 edges, match_count = 2.
4. Complement mode: mode = 1, a = 8'h3C, b = 8'hC3 -> equal = 1, match_count = 8; then a = 8'h3C, b = 8'h3C -> equal = 0, match_count = 0, mismatch_idx = 0.
5. Ignored start: pulse start again in SHIFT cycle 4 with different a/b -> the result reflects the original operands, exactly one done pulse, FSM returns to IDLE.
6. Mid-operation reset: assert rst_n = 0 in SHIFT cycle 5 -> outputs 0 immediately (asynchronous), no done; a following start with a = b = 8'hFF completes normally with equal = 1 and match_count = 8.
